// File: rtl/gate_exerciser.sv
// Drives a 2-input gate under test through all four input vectors,
// samples its output after a programmable settle time and accumulates per-vector results.
module gate_exerciser #(
  parameter logic [3:0]  TRUTH         = 4'b0111,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_vector
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t     r_state,      w_state_nxt;
  logic [3:0] r_settle,     w_settle_nxt;
  logic [1:0] r_idx,        w_idx_nxt;
  logic       r_busy,       w_busy_nxt;
  logic       r_done,       w_done_nxt;
  logic       r_pass,       w_pass_nxt;
  logic [2:0] r_err_count,  w_err_count_nxt;
  logic [3:0] r_err_vector, w_err_vector_nxt;

  logic       w_mismatch;

  // The vector index doubles as the gate drive, so in1/in2 hold their last value in IDLE.
  assign in1        = r_idx[1];
  assign in2        = r_idx[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign err_vector = r_err_vector;

  assign w_mismatch = (gate_out != TRUTH[r_idx]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_settle     <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_err_vector <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle     <= w_settle_nxt;
      r_idx        <= w_idx_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_err_count  <= w_err_count_nxt;
      r_err_vector <= w_err_vector_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_settle_nxt     = r_settle;
    w_idx_nxt        = r_idx;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_pass_nxt       = r_pass;
    w_err_count_nxt  = r_err_count;
    w_err_vector_nxt = r_err_vector;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt      = ST_RUN;
          w_idx_nxt        = '0;
          w_settle_nxt     = LP_SETTLE;
          w_busy_nxt       = 1'b1;
          w_pass_nxt       = 1'b0;
          w_err_count_nxt  = '0;
          w_err_vector_nxt = '0;
        end
      end

      ST_RUN: begin
        if (r_settle != '0) begin
          w_settle_nxt = r_settle - 4'd1;
        end else begin
          if (w_mismatch) begin
            w_err_vector_nxt[r_idx] = 1'b1;
            w_err_count_nxt         = r_err_count + 3'd1;
          end
          if (r_idx == 2'd3) begin
            // Pass uses the updated count so the final vector's result is included.
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_count_nxt == '0);
          end else begin
            w_idx_nxt    = r_idx + 2'd1;
            w_settle_nxt = LP_SETTLE;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: two instances (settle 1 and 3) each with a selectable gate model,
// a per-cycle behavioural reference, and directed runs with literal expectations.
module tb_gate_exerciser;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] start;
  logic [1:0] g_out;
  logic [1:0] in1, in2, busy, done, pass;
  logic [2:0] errc [2];
  logic [3:0] errv [2];

  int gmode [2];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: 0 idle, 1 running, 2 done cycle.
  int         m_st  [2] = '{0, 0};
  int         m_k   [2] = '{0, 0};
  logic [1:0] m_vec [2] = '{2'b00, 2'b00};
  logic [3:0] m_err [2] = '{4'b0000, 4'b0000};
  logic       m_pass[2] = '{1'b0, 1'b0};
  logic [1:0] m_samp;

  always #5 clock = ~clock;

  gate_exerciser #(.TRUTH(4'b0111), .SETTLE_CYCLES(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .gate_out(g_out[0]),
    .in1(in1[0]), .in2(in2[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(errc[0]), .err_vector(errv[0])
  );

  gate_exerciser #(.TRUTH(4'b0111), .SETTLE_CYCLES(3)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .gate_out(g_out[1]),
    .in1(in1[1]), .in2(in2[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(errc[1]), .err_vector(errv[1])
  );

  // Cycles per vector for each instance.
  function automatic int per_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  // Gate models: 0 NAND, 1 AND, 2 stuck-at-1, 3 NAND only when sampled (inverted otherwise).
  function automatic logic gfun(input int mode, input logic [1:0] v, input logic samp);
    logic nand_v;
    nand_v = ~(v[1] & v[0]);
    case (mode)
      0:       return nand_v;
      1:       return ~nand_v;
      2:       return 1'b1;
      default: return samp ? nand_v : ~nand_v;
    endcase
  endfunction

  function automatic logic vec_bad(input int mode, input logic [1:0] v);
    return gfun(mode, v, 1'b1) !== ~(v[1] & v[0]);
  endfunction

  always_comb begin
    m_samp = '0;
    for (int i = 0; i < 2; i++)
      m_samp[i] = (m_st[i] == 1) && (((m_k[i] + 1) % per_of(i)) == 0);
  end

  assign g_out[0] = gfun(gmode[0], {in1[0], in2[0]}, m_samp[0]);
  assign g_out[1] = gfun(gmode[1], {in1[1], in2[1]}, m_samp[1]);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] <= 0; m_k[i] <= 0; m_vec[i] <= 2'b00; m_err[i] <= 4'b0000; m_pass[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_st[i])
          0: if (start[i]) begin
            m_st[i] <= 1; m_k[i] <= 0; m_vec[i] <= 2'b00; m_err[i] <= 4'b0000; m_pass[i] <= 1'b0;
          end
          1: begin
            m_k[i] <= m_k[i] + 1;
            if (((m_k[i] + 1) % per_of(i)) == 0) begin
              if (vec_bad(gmode[i], m_vec[i])) m_err[i][m_vec[i]] <= 1'b1;
              if (m_k[i] + 1 == 4 * per_of(i)) begin
                m_st[i]   <= 2;
                m_pass[i] <= (m_err[i] == 4'b0000) && !vec_bad(gmode[i], m_vec[i]);
              end else begin
                m_vec[i] <= m_vec[i] + 2'd1;
              end
            end
          end
          default: m_st[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d in1", i),  32'(in1[i]),  32'(m_vec[i][1]));
      chk($sformatf("dut%0d in2", i),  32'(in2[i]),  32'(m_vec[i][0]));
      chk($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(m_st[i] == 1));
      chk($sformatf("dut%0d done", i), 32'(done[i]), 32'(m_st[i] == 2));
      chk($sformatf("dut%0d pass", i), 32'(pass[i]), 32'(m_pass[i]));
      chk($sformatf("dut%0d err_count", i),  32'(errc[i]), 32'($countones(m_err[i])));
      chk($sformatf("dut%0d err_vector", i), 32'(errv[i]), 32'(m_err[i]));
    end
  end

  task automatic run_timed(input int i, input int exp_len, input string nm);
    int n;
    @(negedge clock) start[i] = 1'b1;
    @(negedge clock) start[i] = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (done[i]) break;
    end
    chk(nm, 32'(n), 32'(exp_len));
  endtask

  initial begin
    int n_done;
    start    = '0;
    gmode[0] = 0;
    gmode[1] = 3;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset busy", 32'(busy[0]), 0);
    chk("reset pass", 32'(pass[0]), 0);
    chk("reset err_count", 32'(errc[0]), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run_timed(0, 8, "nand run length");
    chk("nand busy at done", 32'(busy[0]), 0);
    chk("nand pass", 32'(pass[0]), 1);
    chk("nand err_count", 32'(errc[0]), 0);
    chk("nand err_vector", 32'(errv[0]), 32'h0);

    gmode[0] = 1;
    run_timed(0, 8, "and run length");
    chk("and pass", 32'(pass[0]), 0);
    chk("and err_count", 32'(errc[0]), 4);
    chk("and err_vector", 32'(errv[0]), 32'hF);

    gmode[0] = 2;
    run_timed(0, 8, "stuck1 run length");
    chk("stuck1 pass", 32'(pass[0]), 0);
    chk("stuck1 err_count", 32'(errc[0]), 1);
    chk("stuck1 err_vector", 32'(errv[0]), 32'h8);

    gmode[0] = 0;
    @(negedge clock) start[0] = 1'b1;
    n_done = 0;
    repeat (11) begin
      @(negedge clock);
      if (done[0]) begin
        n_done++;
        chk("held-start run1 pass", 32'(pass[0]), 1);
      end
    end
    chk("held-start done count", 32'(n_done), 1);
    chk("held-start rerun busy", 32'(busy[0]), 1);
    chk("held-start rerun pass cleared", 32'(pass[0]), 0);
    start[0] = 1'b0;
    n_done = 0;
    while (n_done < 30 && !done[0]) begin
      @(negedge clock);
      n_done++;
    end
    chk("held-start run2 done", 32'(done[0]), 1);

    @(negedge clock) start[0] = 1'b1;
    @(negedge clock) start[0] = 1'b0;
    repeat (2) @(negedge clock);
    chk("pre-reset in2", 32'(in2[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid-run reset busy", 32'(busy[0]), 0);
    chk("mid-run reset in1", 32'(in1[0]), 0);
    chk("mid-run reset in2", 32'(in2[0]), 0);
    chk("mid-run reset err_count", 32'(errc[0]), 0);
    chk("mid-run reset pass", 32'(pass[0]), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clock);
      if (done[0]) n_done++;
    end
    chk("no done after reset", 32'(n_done), 0);
    run_timed(0, 8, "post-reset run length");
    chk("post-reset pass", 32'(pass[0]), 1);

    run_timed(1, 16, "settle3 run length");
    chk("settle3 glitch pass", 32'(pass[1]), 1);
    chk("settle3 glitch err_count", 32'(errc[1]), 0);
    chk("settle3 glitch err_vector", 32'(errv[1]), 32'h0);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
